// File: rtl/multi_debouncer_pkg.sv
// rtl/multi_debouncer_pkg.sv - shared FSM encoding and counter width helpers for multi_debouncer
package multi_debouncer_pkg;

  // Per-channel FSM state encoding
  localparam logic [1:0] ST_RELEASED        = 2'd0;
  localparam logic [1:0] ST_PRESS_PENDING   = 2'd1;
  localparam logic [1:0] ST_PRESSED         = 2'd2;
  localparam logic [1:0] ST_RELEASE_PENDING = 2'd3;

  // Bits needed to hold values 0..max_val (never less than one bit)
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= max_val) w = i + 1;
    end
    return w;
  endfunction

  // Largest of three tick parameters, used to size one shared counter width
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/multi_debouncer_channel.sv
// rtl/multi_debouncer_channel.sv - one debounced input: synchroniser, press/release FSM, hold and repeat counters
module multi_debouncer_channel
  import multi_debouncer_pkg::*;
#(
  parameter int   DEBOUNCE_TICKS   = 16,
  parameter int   SYNC_STAGES      = 2,
  parameter int   LONG_PRESS_TICKS = 64,
  parameter int   REPEAT_TICKS     = 16,
  parameter logic INVERT           = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic raw_in,
  output logic level_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic repeat_pulse
);

  localparam int CW = cnt_width(max3(DEBOUNCE_TICKS, LONG_PRESS_TICKS, REPEAT_TICKS));
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_PRESS_TICKS);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_TICKS - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TICKS - 1);
  localparam logic LONG_EN = (LONG_PRESS_TICKS != 0);
  localparam logic REP_EN  = (LONG_PRESS_TICKS != 0) && (REPEAT_TICKS != 0);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          deb_cnt_q, deb_cnt_d;
  logic [CW-1:0]          hold_cnt_q, hold_cnt_d;
  logic [CW-1:0]          rep_cnt_q, rep_cnt_d;
  logic                   long_ev_q, long_ev_d;
  logic                   rep_ev_q, rep_ev_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   long_q, long_d;
  logic                   repeat_q, repeat_d;
  logic                   synced;
  logic                   in_hold;

  // Inversion is applied after the last stage so active-low inputs share the same flops
  assign synced  = sync_q[SYNC_STAGES-1] ^ INVERT;
  assign in_hold = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_PENDING);

  // Shift the raw input through the synchroniser on every clk
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  // Debounce FSM plus hold/repeat counting; events only fire while genuinely pressed
  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    long_ev_d  = 1'b0;
    rep_ev_d   = 1'b0;

    if (ce && in_hold) begin
      if (LONG_EN && (hold_cnt_q != LONG_MAX)) begin
        hold_cnt_d = hold_cnt_q + CW'(1);
        if (hold_cnt_q == LONG_LAST) begin
          rep_cnt_d = '0;
          long_ev_d = (state_q == ST_PRESSED);
        end
      end else if (REP_EN && (hold_cnt_q == LONG_MAX)) begin
        if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d = '0;
          rep_ev_d  = (state_q == ST_PRESSED);
        end else begin
          rep_cnt_d = rep_cnt_q + CW'(1);
        end
      end
    end

    case (state_q)
      ST_RELEASED: begin
        if (ce && synced) begin
          state_d   = ST_PRESS_PENDING;
          deb_cnt_d = CW'(1);
        end
      end
      ST_PRESS_PENDING: begin
        if (!synced) begin
          state_d   = ST_RELEASED;
          deb_cnt_d = '0;
        end else if (ce) begin
          if (deb_cnt_q == DEB_LAST) begin
            state_d    = ST_PRESSED;
            deb_cnt_d  = '0;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + CW'(1);
          end
        end
      end
      ST_PRESSED: begin
        if (ce && !synced) begin
          state_d   = ST_RELEASE_PENDING;
          deb_cnt_d = CW'(1);
        end
      end
      ST_RELEASE_PENDING: begin
        if (synced) begin
          state_d   = ST_PRESSED;
          deb_cnt_d = '0;
        end else if (ce) begin
          if (deb_cnt_q == DEB_LAST) begin
            state_d    = ST_RELEASED;
            deb_cnt_d  = '0;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d   = ST_RELEASED;
        deb_cnt_d = '0;
      end
    endcase
  end

  // Output stage: level follows the FSM one clk later, edges of it become the pulses
  always_comb begin
    level_d   = in_hold;
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
    long_d    = long_ev_q;
    repeat_d  = rep_ev_q;
  end

  // All state registers; reset clears everything, so a held press drops without a release pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= '0;
      state_q    <= ST_RELEASED;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      long_ev_q  <= 1'b0;
      rep_ev_q   <= 1'b0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      long_ev_q  <= long_ev_d;
      rep_ev_q   <= rep_ev_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  assign level_out        = level_q;
  assign press_pulse      = press_q;
  assign release_pulse    = release_q;
  assign long_press_pulse = long_q;
  assign repeat_pulse     = repeat_q;

endmodule

// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - N independent debounced inputs with press/release/long-press/repeat pulses
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int                  CHANNELS         = 4,
  parameter int                  DEBOUNCE_TICKS   = 16,
  parameter int                  SYNC_STAGES      = 2,
  parameter int                  LONG_PRESS_TICKS = 64,
  parameter int                  REPEAT_TICKS     = 16,
  parameter logic [CHANNELS-1:0] INVERT_MASK      = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                CLOCK_ENABLE,
  input  logic [CHANNELS-1:0] in_signal,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_press_pulse,
  output logic [CHANNELS-1:0] repeat_pulse
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    multi_debouncer_channel #(
      .DEBOUNCE_TICKS  (DEBOUNCE_TICKS),
      .SYNC_STAGES     (SYNC_STAGES),
      .LONG_PRESS_TICKS(LONG_PRESS_TICKS),
      .REPEAT_TICKS    (REPEAT_TICKS),
      .INVERT          (INVERT_MASK[g])
    ) u_ch (
      .clk             (clk),
      .rst_n           (rst_n),
      .ce              (CLOCK_ENABLE),
      .raw_in          (in_signal[g]),
      .level_out       (level_out[g]),
      .press_pulse     (press_pulse[g]),
      .release_pulse   (release_pulse[g]),
      .long_press_pulse(long_press_pulse[g]),
      .repeat_pulse    (repeat_pulse[g])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - directed self-checking bench for multi_debouncer
module tb_multi_debouncer;

  localparam logic [3:0] INV  = 4'b1000;
  localparam int         NONE = 1 << 30;

  logic       clk;
  logic       rst_n;
  logic       clock_enable;
  logic [3:0] in_signal;
  logic [3:0] level_out, press_pulse, release_pulse, long_press_pulse, repeat_pulse;
  logic [19:0] got;

  int checks;
  int failures;

  multi_debouncer #(
    .CHANNELS        (4),
    .DEBOUNCE_TICKS  (16),
    .SYNC_STAGES     (2),
    .LONG_PRESS_TICKS(64),
    .REPEAT_TICKS    (16),
    .INVERT_MASK     (INV)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .CLOCK_ENABLE    (clock_enable),
    .in_signal       (in_signal),
    .level_out       (level_out),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse),
    .repeat_pulse    (repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign got = {level_out, press_pulse, release_pulse, long_press_pulse, repeat_pulse};

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%05h exp=%05h", tag, obs, exp);
    end
  endtask

  // Drive one channel for 'total' clks (active for the first 'hold'), checking every clk.
  // Edge c=0 is the first edge sampling the active value; event times are edge indices.
  task automatic run_case(input string tag, input int ch, input int hold, input int total,
                          input int press_at, input int rel_at, input int long_at,
                          input int rep_n, input bit lvl0, input int ce_period);
    logic [19:0] exp;
    logic        lv, rp;
    for (int c = 0; c < total; c++) begin
      in_signal[ch] = (c < hold) ? ~INV[ch] : INV[ch];
      clock_enable  = ((c % ce_period) == 0);
      @(posedge clk);
      #1;
      lv = (c < rel_at) && (lvl0 || (press_at >= 0 && c >= press_at));
      rp = (long_at >= 0) && (rep_n > 0) && (c > long_at) &&
           (((c - long_at) % 16) == 0) && (((c - long_at) / 16) <= rep_n);
      exp = '0;
      exp[16+ch] = lv;
      exp[12+ch] = (c == press_at);
      exp[8+ch]  = (c == rel_at);
      exp[4+ch]  = (c == long_at);
      exp[ch]    = rp;
      check($sformatf("%s c=%0d", tag, c), got, exp);
    end
    clock_enable = 1'b1;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    clock_enable = 1'b1;
    in_signal    = INV;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", got, 20'h0);
    rst_n = 1'b1;

    // Quiet after reset, including the inverted channel while its synchroniser fills
    run_case("idle", 0, 0, 20, -1, NONE, -1, 0, 1'b0, 1);

    // Clean press on ch0, then release
    run_case("ch0_clean", 0, 40, 70, 18, 58, -1, 0, 1'b0, 1);

    // Jitter burst shorter than the debounce window, then short press
    for (int i = 0; i < 50; i++) begin
      in_signal[0] = 1'($urandom_range(1, 0));
      #3;
    end
    in_signal[0] = 1'b0;
    @(posedge clk);
    #1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("jitter_quiet", got, 20'h0);
    run_case("ch0_short", 0, 12, 44, -1, NONE, -1, 0, 1'b0, 1);

    // Long hold on ch1: long press at 82, repeats every 16 clks while pressed, release at 218
    run_case("ch1_long", 1, 200, 240, 18, 218, 82, 7, 1'b0, 1);

    // Active-low channel
    run_case("ch3_inv", 3, 30, 60, 18, 48, -1, 0, 1'b0, 1);

    // Clock enable 1-in-4: 16 enabled ticks after sync, press visible at edge 65
    run_case("ce_press", 0, 80, 80, 65, NONE, -1, 0, 1'b0, 4);
    run_case("ce_release", 0, 0, 25, -1, 18, -1, 0, 1'b1, 1);

    // Reset while ch2 is held: outputs clear with no release pulse, then a fresh press
    run_case("ch2_press", 2, 40, 40, 18, NONE, -1, 0, 1'b0, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset_mid_press", got, 20'h0);
    rst_n = 1'b1;
    run_case("ch2_fresh", 2, 40, 40, 18, NONE, -1, 0, 1'b0, 1);
    run_case("ch2_release", 2, 0, 25, -1, 18, -1, 0, 1'b1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
